// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-client round-robin sequencer for the
// single i2c_wrapper command port.
module mem_port_arbiter #(
  parameter int DATAWIDTH  = 8,
  parameter int ADDRWIDTH  = 4,
  parameter int WRITE_LAT  = 4,
  parameter int RD_TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         r0_req,
  input  logic                         r0_we,
  input  logic [ADDRWIDTH-1:0]         r0_addr,
  input  logic [DATAWIDTH-1:0]         r0_wdata,
  output logic                         r0_ack,
  output logic                         r0_rvalid,
  output logic [DATAWIDTH-1:0]         r0_rdata,
  input  logic                         r1_req,
  input  logic                         r1_we,
  input  logic [ADDRWIDTH-1:0]         r1_addr,
  input  logic [DATAWIDTH-1:0]         r1_wdata,
  output logic                         r1_ack,
  output logic                         r1_rvalid,
  output logic [DATAWIDTH-1:0]         r1_rdata,
  output logic                         rd_err,
  output logic                         busy,
  output logic                         wr_en,
  output logic                         rd_en,
  output logic [ADDRWIDTH-1:0]         addr,
  output logic [DATAWIDTH-1:0]         D,
  output logic [$clog2(DATAWIDTH)-1:0] S,
  output logic                         MSBIn,
  output logic                         LSBIn,
  input  logic [DATAWIDTH-1:0]         dataout,
  input  logic                         DataValid
);

  localparam int LAT_MAX =
    (WRITE_LAT > RD_TIMEOUT) ? WRITE_LAT : RD_TIMEOUT;
  localparam int CW = $clog2(LAT_MAX + 1);
  localparam int SW = $clog2(DATAWIDTH);
  localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LAT - 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WR_WAIT,
    RD_WAIT,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic                 pri;
  logic                 gnt_id;
  logic                 lat_we;
  logic [ADDRWIDTH-1:0] lat_addr;
  logic [DATAWIDTH-1:0] lat_wdata;
  logic [CW-1:0]        cnt;
  logic                 ok_flag;
  logic                 err_flag;

  logic req_any;
  logic pick_r1;
  logic cnt_zero;

  // Round-robin pick: r1 wins when alone or when it holds priority
  always_comb begin
    req_any  = r0_req | r1_req;
    pick_r1  = r1_req & (~r0_req | pri);
    cnt_zero = (cnt == '0);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req_any) state_nx = ISSUE;
      ISSUE:   state_nx = lat_we ? WR_WAIT : RD_WAIT;
      WR_WAIT: if (cnt_zero) state_nx = DONE;
      RD_WAIT: if (DataValid || cnt_zero) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Grant latch, priority flip and shared latency counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pri       <= 1'b0;
      gnt_id    <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= '0;
      ok_flag   <= 1'b0;
      err_flag  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_any) begin
            gnt_id    <= pick_r1;
            pri       <= ~pick_r1;
            lat_we    <= pick_r1 ? r1_we    : r0_we;
            lat_addr  <= pick_r1 ? r1_addr  : r0_addr;
            lat_wdata <= pick_r1 ? r1_wdata : r0_wdata;
            ok_flag   <= 1'b0;
            err_flag  <= 1'b0;
          end
        end
        ISSUE: cnt <= lat_we ? WR_LOAD : RD_LOAD;
        WR_WAIT: begin
          if (!cnt_zero) cnt <= cnt - CW'(1);
        end
        RD_WAIT: begin
          if (DataValid)     ok_flag  <= 1'b1;
          else if (cnt_zero) err_flag <= 1'b1;
          else               cnt      <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Read data capture into the owning client's register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r0_rdata <= '0;
      r1_rdata <= '0;
    end else if (state == RD_WAIT && DataValid) begin
      if (gnt_id) r1_rdata <= dataout;
      else        r0_rdata <= dataout;
    end
  end

  // Output decode from registered state only
  always_comb begin
    busy      = (state != IDLE);
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    r0_ack    = 1'b0;
    r1_ack    = 1'b0;
    r0_rvalid = 1'b0;
    r1_rvalid = 1'b0;
    rd_err    = 1'b0;
    unique case (state)
      ISSUE: begin
        wr_en = lat_we;
        rd_en = ~lat_we;
      end
      DONE: begin
        r0_ack    = ~gnt_id;
        r1_ack    = gnt_id;
        r0_rvalid = ~gnt_id & ok_flag;
        r1_rvalid = gnt_id & ok_flag;
        rd_err    = err_flag;
      end
      default: ;
    endcase
  end

  assign addr  = lat_addr;
  assign D     = lat_wdata;
  assign S     = SW'(1);
  assign MSBIn = 1'b0;
  assign LSBIn = 1'b0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench with a
// behavioural wrapper memory on the command port.
module tb_mem_port_arbiter;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int WL = 4;
  localparam int RT = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          r0_req = 1'b0, r1_req = 1'b0;
  logic          r0_we = 1'b0, r1_we = 1'b0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
  logic          r0_ack, r1_ack, r0_rvalid, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          rd_err, busy, wr_en, rd_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] D;
  logic [2:0]    S;
  logic          MSBIn, LSBIn;
  logic [DW-1:0] dataout = '0;
  logic          dv_model = 1'b0;
  logic          dv_stray = 1'b0;
  logic          DataValid;

  assign DataValid = dv_model | dv_stray;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .DATAWIDTH(DW), .ADDRWIDTH(AW),
    .WRITE_LAT(WL), .RD_TIMEOUT(RT)
  ) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rvalid(r0_rvalid),
    .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rvalid(r1_rvalid),
    .r1_rdata(r1_rdata),
    .rd_err(rd_err), .busy(busy),
    .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .D(D), .S(S),
    .MSBIn(MSBIn), .LSBIn(LSBIn),
    .dataout(dataout), .DataValid(DataValid)
  );

  typedef struct {
    int          id;
    bit          rd;
    bit          err;
    logic [7:0]  data;
    int          cyc;
  } exp_t;

  exp_t       expq[$];
  int         n_vec = 0;
  int         n_miss = 0;
  int         cyc = 0;
  logic [7:0] mem [16];
  logic [7:0] model_mem [16];
  int         dv_delay = 3;
  int         rd_wait = 0;
  logic [7:0] rd_data = '0;
  int         wr_cnt = 0;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(posedge clk) cyc++;

  // wrapper model: writes land on wr_en, reads answer dv_delay later
  always @(negedge clk) begin
    if (wr_en) begin
      mem[addr] = D;
      wr_cnt++;
    end
    if (rd_wait > 0) begin
      rd_wait--;
      dv_model = (rd_wait == 0);
      if (rd_wait == 0) dataout = rd_data;
    end else begin
      dv_model = 1'b0;
    end
    if (rd_en && dv_delay > 0) begin
      rd_wait = dv_delay;
      rd_data = mem[addr];
    end
  end

  // monitor: pop and compare on every ack
  always @(negedge clk) begin
    exp_t e;
    chk("cmd_exclusive", {31'd0, wr_en & rd_en}, 0);
    if (r0_ack || r1_ack) begin
      if (expq.size() == 0) begin
        chk("unexpected_ack", {30'd0, r1_ack, r0_ack}, 0);
      end else begin
        e = expq.pop_front();
        chk("ack_id", {30'd0, r1_ack, r0_ack},
            (e.id != 0) ? 32'd2 : 32'd1);
        chk("rvalid", (e.id != 0) ? r1_rvalid : r0_rvalid,
            {31'd0, e.rd && !e.err});
        chk("other_rvalid", (e.id != 0) ? r0_rvalid : r1_rvalid, 0);
        chk("rd_err", rd_err, {31'd0, e.err});
        if (e.rd && !e.err)
          chk("rdata", (e.id != 0) ? r1_rdata : r0_rdata, e.data);
        if (e.cyc >= 0) chk("ack_cycle", cyc, e.cyc);
      end
    end else begin
      chk("stray_pulse", {29'd0, r0_rvalid, r1_rvalid, rd_err}, 0);
    end
  end

  function automatic void push_exp(int id, bit rd, bit err,
                                   logic [7:0] data, int c);
    exp_t e;
    e.id = id; e.rd = rd; e.err = err; e.data = data; e.cyc = c;
    expq.push_back(e);
  endfunction

  task automatic drive(input int id, input bit we,
                       input logic [3:0] a, input logic [7:0] d);
    bit got;
    got = 1'b0;
    if (id == 0) begin
      r0_we = we; r0_addr = a; r0_wdata = d; r0_req = 1'b1;
    end else begin
      r1_we = we; r1_addr = a; r1_wdata = d; r1_req = 1'b1;
    end
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = (id != 0) ? r1_ack : r0_ack;
    end
    chk("ack_timeout", {31'd0, got}, 1);
    @(posedge clk);
    #1;
    if (id == 0) r0_req = 1'b0;
    else         r1_req = 1'b0;
  endtask

  // issued from an idle arbiter: t0 is the current cycle
  task automatic issue(input int id, input bit we, input logic [3:0] a,
                       input logic [7:0] d, input int lat);
    bit err;
    err = !we && dv_delay == 0;
    push_exp(id, !we, err, model_mem[a], (lat < 0) ? -1 : cyc + lat);
    if (we) model_mem[a] = d;
    drive(id, we, a, d);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w0;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobes", {24'd0, wr_en, rd_en, busy, rd_err,
        r0_ack, r1_ack, r0_rvalid, r1_rvalid}, 0);
    chk("rst_addr_d", {20'd0, addr, D}, 0);
    chk("rst_rdata", {16'd0, r0_rdata, r1_rdata}, 0);
    chk("rst_S", {29'd0, S}, 1);
    chk("rst_shift_in", {30'd0, MSBIn, LSBIn}, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    w0 = wr_cnt;
    issue(0, 1'b1, 4'd3, 8'hA5, WL + 2);
    chk("wr_pulses", wr_cnt - w0, 1);
    chk("mem3", {24'd0, mem[3]}, 32'hA5);
    issue(0, 1'b1, 4'd7, 8'h5A, WL + 2);
    issue(1, 1'b0, 4'd7, 8'h00, 5);
    repeat (3) @(posedge clk);
    #1;
    chk("r1_rdata_held", {24'd0, r1_rdata}, 32'h5A);
    chk("r0_rdata_zero", {24'd0, r0_rdata}, 0);

    do_reset();
    for (int i = 0; i < 6; i++) begin
      push_exp(0, 1'b0, 1'b0, 8'h00, -1);
      model_mem[i] = 8'h10 + 8'(i);
      push_exp(1, 1'b1, 1'b0, 8'h10 + 8'(i), -1);
    end
    fork
      begin
        for (int i = 0; i < 6; i++)
          drive(0, 1'b1, 4'(i), 8'h10 + 8'(i));
      end
      begin
        for (int j = 0; j < 6; j++)
          drive(1, 1'b0, 4'(j), 8'h00);
      end
    join

    issue(0, 1'b0, 4'd3, 8'h00, 5);
    chk("r0_rdata_read", {24'd0, r0_rdata}, 32'h13);
    dv_delay = 0;
    issue(0, 1'b0, 4'd5, 8'h00, RT + 2);
    dv_delay = 3;
    chk("r0_rdata_kept", {24'd0, r0_rdata}, 32'h13);

    r0_we = 1'b1; r0_addr = 4'd9; r0_wdata = 8'h99; r0_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_wr_wait", {31'd0, busy}, 1);
    reset = 1'b0;
    #1;
    r0_req = 1'b0;
    model_mem[9] = 8'h99;
    chk("abort_strobes", {24'd0, wr_en, rd_en, busy, rd_err,
        r0_ack, r1_ack, r0_rvalid, r1_rvalid}, 0);
    chk("abort_addr_d", {20'd0, addr, D}, 0);
    chk("abort_rdata", {16'd0, r0_rdata, r1_rdata}, 0);
    chk("mem9", {24'd0, mem[9]}, 32'h99);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    dv_stray = 1'b1;
    @(posedge clk);
    #1;
    dv_stray = 1'b0;
    chk("busy_after_stray", {31'd0, busy}, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_stray", {30'd0, busy, r1_rvalid}, 0);
    issue(1, 1'b0, 4'd9, 8'h00, 5);
    issue(1, 1'b1, 4'd2, 8'h2B, WL + 2);

    for (int i = 0; i < 16; i++)
      issue(i % 2, 1'b1, 4'(i), 8'($urandom), WL + 2);
    for (int i = 0; i < 16; i++)
      issue((i + 1) % 2, 1'b0, 4'(i), 8'h00, 5);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester round-robin arbiter and sequencer for the single command port of `i2c_wrapper`. It accepts word-wide read/write requests from two independent clients and serialises them onto `wr_en`/`rd_en`/`addr`/`D`. It enforces the wrapper's write recovery latency, waits for `DataValid` on reads and routes `dataout` back to the owning client. It sits between the system clients and `i2c_wrapper`, and drives the wrapper's shift-register controls to fixed parallel-load values.

## Interface
- `DATAWIDTH`, 8: data word width.
- `ADDRWIDTH`, 4: memory address width.
- `WRITE_LAT`, 4: idle cycles the wrapper requires after a one-cycle `wr_en` pulse.
- `RD_TIMEOUT`, 64: maximum cycles to wait for `DataValid` after `rd_en`.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `r0_req`, `r1_req`  in  1  request; held high until the matching ack.
- `r0_we`, `r1_we`  in  1  1 = write, 0 = read; stable while req is high.
- `r0_addr`, `r1_addr`  in  ADDRWIDTH  request address; stable while req is high.
- `r0_wdata`, `r1_wdata`  in  DATAWIDTH  write data; stable while req is high.
- `r0_ack`, `r1_ack`  out  1  one-cycle pulse: request completed.
- `r0_rvalid`, `r1_rvalid`  out  1  one-cycle pulse with ack on a successful read.
- `r0_rdata`, `r1_rdata`  out  DATAWIDTH  last successful read data; held between reads.
- `rd_err`  out  1  one-cycle pulse with ack on a read timeout.
- `busy`  out  1  high in every state except IDLE.
- `wr_en`, `rd_en`  out  1  wrapper command strobes; never high together.
- `addr`  out  ADDRWIDTH  wrapper address.
- `D`  out  DATAWIDTH  wrapper write data.
- `S`  out  $clog2(DATAWIDTH)  constant 1 (parallel load).
- `MSBIn`, `LSBIn`  out  1  constant 0.
- `dataout`  in  DATAWIDTH  wrapper read data; valid when `DataValid` is high.
- `DataValid`  in  1  wrapper read-data valid.

## Operation
- **States:** IDLE, ISSUE, WR_WAIT, RD_WAIT, DONE.
- **IDLE:**
  - Sample `r0_req` and `r1_req`. If neither is high, stay.
  - If one is high, grant it. If both are high, grant the one selected by `pri` (0 = r0).
  - Latch grant id, we, addr and wdata, then go to ISSUE.
  - On every grant, `pri` is set to the non-granted requester.
- **ISSUE (one cycle):**
  - `addr` and `D` carry the latched values.
  - `wr_en` = we and `rd_en` = !we.
  - Next state is WR_WAIT if we, otherwise RD_WAIT.
- **WR_WAIT:** count WRITE_LAT cycles, then go to DONE. `DataValid` is ignored.
- **RD_WAIT:**
  - If `DataValid` is sampled high, capture `dataout` into the granted requester's rdata, set an ok flag and go to DONE.
  - If RD_TIMEOUT cycles elapse in RD_WAIT without `DataValid`, set an error flag and go to DONE; rdata is unchanged.
- **DONE (one cycle):**
  - The granted requester's ack is high.
  - rvalid is high if the read succeeded; `rd_err` is high if the read timed out.
  - Next state is IDLE.
- **Output timing:** all handshake outputs are decoded from registered state only (no input-to-output paths).
- `addr` and `D` hold their last driven values outside ISSUE.
- `DataValid` outside RD_WAIT is ignored.
- **Requester rule:** after seeing ack, a requester drops req or presents a new request by the next edge. IDLE then samples fresh values, so no request is issued twice.
- **Counter:** one shared down-counter, width $clog2(max(WRITE_LAT, RD_TIMEOUT)+1). It is loaded on ISSUE exit; no wrap-around.

## Timing
- **Reset values:**
  - state IDLE, `pri` 0, `busy` 0.
  - `wr_en`, `rd_en`, `addr` and `D` all 0.
  - All acks, rvalids, rdata and `rd_err` 0.
  - `S` = 1, `MSBIn` = 0, `LSBIn` = 0.
- Reset asserted mid-operation aborts the transaction immediately. No ack is given, and any late `DataValid` is ignored.
- Let t0 be the IDLE cycle in which req is sampled.
- **Write:**
  - `wr_en` is high in t0+1 only.
  - Ack is high in t0+2+WRITE_LAT.
- **Read:**
  - `rd_en` is high in t0+1 only.
  - If `DataValid` is first high in cycle t0+1+k (k ≥ 1), ack and rvalid are high in t0+2+k.
- **Read timeout:** ack and `rd_err` are high in t0+2+RD_TIMEOUT.
- **Throughput:** minimum gap between consecutive wrapper commands is WRITE_LAT+3 cycles for writes.
- **Both requesters holding req continuously:** grants alternate r0, r1, r0, … starting with r0 after reset.

## Test plan
- **Single write:** WRITE_LAT=4; r0 writes addr 3, data 0xA5.
  - `wr_en` is high for exactly one cycle with addr=3 and D=0xA5.
  - `r0_ack` is high at t0+6.
  - The wrapper memory holds 0xA5 at address 3.
- **Single read:** r1 reads addr 7; `DataValid` arrives 3 cycles after `rd_en` with `dataout`=0x5A.
  - `r1_ack` and `r1_rvalid` pulse together at t0+5.
  - `r1_rdata` = 0x5A and stays 0x5A afterwards.
  - r0 outputs remain 0.
- **Contention:** after reset both requesters hold req continuously for 6 requests each.
  - Grant order is r0, r1, r0, r1, …
  - `wr_en` and `rd_en` are never high together.
- **Read timeout:** RD_TIMEOUT=8; r0 reads and `DataValid` is held low.
  - `r0_ack` and `rd_err` pulse at t0+10.
  - `r0_rvalid` stays 0 and `r0_rdata` is unchanged.
- **Reset mid-write:** `reset` is driven low during WR_WAIT, then released.
  - All outputs return to reset values immediately.
  - A stray `DataValid` pulse in IDLE has no effect.
  - The next r1-only request is served normally.
- **Full fill and readback:** r0 and r1 alternately write random data to all 2^ADDRWIDTH addresses, then read every address back.
  - Every read matches a scoreboard model of memory.
